// File: rtl/ir_prefetch.sv
// Instruction register fed by a small prefetch queue; multi-beat memory words
// are assembled MSB-first into full instructions before entering the queue.
module ir_prefetch #(
    parameter int MEM_W  = 8,
    parameter int OPC_W  = 3,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 2,
    localparam int INSTR_W = OPC_W + ADDR_W,
    localparam int BEATS   = (INSTR_W + MEM_W - 1) / MEM_W,
    localparam int CW      = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic [MEM_W-1:0]  mem_data,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic              ld_ir,
    output logic [OPC_W-1:0]  opcode,
    output logic [ADDR_W-1:0] address,
    output logic              ir_valid,
    output logic [CW-1:0]     q_count,
    output logic              ld_err
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [INSTR_W-1:0] fifo [DEPTH];
    logic [PW-1:0]      rd_ptr;
    logic [PW-1:0]      wr_ptr;
    logic [1:0]         beat_cnt;
    logic [INSTR_W-1:0] asm_reg;
    logic [INSTR_W-1:0] asm_next;
    logic               accept;
    logic               last_beat;
    logic               push;
    logic               pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // NOTE: mem_ready looks only at flush and registered state, never at
    // mem_valid, so the handshake cannot form a combinational loop upstream.
    assign mem_ready = !flush && (q_count < CW'(DEPTH));
    assign accept    = mem_valid && mem_ready;
    assign last_beat = (beat_cnt == 2'(BEATS - 1));
    assign push      = accept && last_beat;
    assign pop       = ld_ir && !flush && (q_count != '0);

    // Only the low INSTR_W bits of the beat history can reach the final word.
    assign asm_next  = INSTR_W'({asm_reg, mem_data});

    // NOTE: the queue storage has no reset; q_count and the pointers decide
    // which entries are meaningful, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo[wr_ptr] <= asm_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opcode   <= '0;
            address  <= '0;
            ir_valid <= 1'b0;
            ld_err   <= 1'b0;
            q_count  <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            beat_cnt <= '0;
            asm_reg  <= '0;
        end else if (flush) begin
            // The executing instruction in the IR survives a flush.
            ld_err   <= 1'b0;
            q_count  <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            beat_cnt <= '0;
            asm_reg  <= '0;
        end else begin
            ld_err <= ld_ir && (q_count == '0);

            if (accept) begin
                if (last_beat) begin
                    beat_cnt <= '0;
                    asm_reg  <= '0;
                    wr_ptr   <= next_ptr(wr_ptr);
                end else begin
                    beat_cnt <= beat_cnt + 2'd1;
                    asm_reg  <= asm_next;
                end
            end

            if (pop) begin
                opcode   <= fifo[rd_ptr][INSTR_W-1:ADDR_W];
                address  <= fifo[rd_ptr][ADDR_W-1:0];
                ir_valid <= 1'b1;
                rd_ptr   <= next_ptr(rd_ptr);
            end

            case ({push, pop})
                2'b10:   q_count <= q_count + CW'(1);
                2'b01:   q_count <= q_count - CW'(1);
                default: q_count <= q_count;
            endcase
        end
    end

endmodule

// File: tb/tb_ir_prefetch.sv
// Scoreboard bench for ir_prefetch: default config (A) and a two-beat,
// depth-3 config (B) run side by side on one clock.
module tb_ir_prefetch;

    typedef struct {
        logic [3:0]  opc;
        logic [11:0] adr;
        logic        vld;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    // Instance A: MEM_W=8, OPC_W=3, ADDR_W=5, DEPTH=2
    logic       a_flush, a_valid, a_ready, a_ld, a_irv, a_err;
    logic [7:0] a_data;
    logic [2:0] a_opc;
    logic [4:0] a_adr;
    logic [1:0] a_cnt;

    // Instance B: MEM_W=8, OPC_W=4, ADDR_W=12, DEPTH=3
    logic        b_flush, b_valid, b_ready, b_ld, b_irv, b_err;
    logic [7:0]  b_data;
    logic [3:0]  b_opc;
    logic [11:0] b_adr;
    logic [1:0]  b_cnt;

    int   n_vec = 0;
    int   n_err = 0;
    exp_t a_q[$];
    exp_t b_q[$];
    bit   a_cap, b_cap;

    ir_prefetch u_a (
        .clk(clk), .rst(rst), .flush(a_flush),
        .mem_data(a_data), .mem_valid(a_valid), .mem_ready(a_ready),
        .ld_ir(a_ld), .opcode(a_opc), .address(a_adr),
        .ir_valid(a_irv), .q_count(a_cnt), .ld_err(a_err)
    );

    ir_prefetch #(.MEM_W(8), .OPC_W(4), .ADDR_W(12), .DEPTH(3)) u_b (
        .clk(clk), .rst(rst), .flush(b_flush),
        .mem_data(b_data), .mem_valid(b_valid), .mem_ready(b_ready),
        .ld_ir(b_ld), .opcode(b_opc), .address(b_adr),
        .ir_valid(b_irv), .q_count(b_cnt), .ld_err(b_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [3:0] opc, input logic [11:0] adr,
                                input logic vld, input logic err);
        exp_t e;
        e.opc = opc;
        e.adr = adr;
        e.vld = vld;
        e.err = err;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_drive(input logic v, input logic [7:0] d, input logic l);
        a_valid = v;
        a_data  = d;
        a_ld    = l;
    endtask

    task automatic b_drive(input logic v, input logic [7:0] d, input logic l, input logic f);
        b_valid = v;
        b_data  = d;
        b_ld    = l;
        b_flush = f;
    endtask

    // Monitor A: every accepted ld_ir is followed by one IR/ld_err comparison.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            a_cap = a_ld && !a_flush && !rst;
            @(negedge clk);
            if (a_cap) begin
                if (a_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL a_sb_underflow: load observed with no expected entry at %0t", $time);
                end else begin
                    e = a_q.pop_front();
                    check("a_opcode",   32'(a_opc), 32'(e.opc));
                    check("a_address",  32'(a_adr), 32'(e.adr));
                    check("a_ir_valid", 32'(a_irv), 32'(e.vld));
                    check("a_ld_err",   32'(a_err), 32'(e.err));
                end
            end
        end
    end

    // Monitor B
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            b_cap = b_ld && !b_flush && !rst;
            @(negedge clk);
            if (b_cap) begin
                if (b_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL b_sb_underflow: load observed with no expected entry at %0t", $time);
                end else begin
                    e = b_q.pop_front();
                    check("b_opcode",   32'(b_opc), 32'(e.opc));
                    check("b_address",  32'(b_adr), 32'(e.adr));
                    check("b_ir_valid", 32'(b_irv), 32'(e.vld));
                    check("b_ld_err",   32'(b_err), 32'(e.err));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        a_flush = 1'b0;
        a_drive(1'b0, 8'h00, 1'b0);
        b_drive(1'b0, 8'h00, 1'b0, 1'b0);
        repeat (2) tick();
        rst = 1'b0;

        // Reset state
        check("a_rst_opcode", 32'(a_opc), 0);
        check("a_rst_addr",   32'(a_adr), 0);
        check("a_rst_irv",    32'(a_irv), 0);
        check("a_rst_err",    32'(a_err), 0);
        check("a_rst_cnt",    32'(a_cnt), 0);
        check("a_rst_ready",  32'(a_ready), 1);
        check("b_rst_cnt",    32'(b_cnt), 0);
        check("b_rst_ready",  32'(b_ready), 1);

        // ld_ir on an empty queue straight after reset: one-cycle error, IR untouched
        a_drive(1'b0, 8'h00, 1'b1);
        a_q.push_back(mk(4'd0, 12'd0, 1'b0, 1'b1));
        tick();
        a_drive(1'b0, 8'h00, 1'b0);
        tick();
        check("a_err_one_cycle", 32'(a_err), 0);

        // Single push then pop: A7 -> opcode 101, address 00111
        a_drive(1'b1, 8'hA7, 1'b0);
        tick();
        check("a_cnt_after_push", 32'(a_cnt), 1);
        a_drive(1'b0, 8'h00, 1'b1);
        a_q.push_back(mk(4'd5, 12'd7, 1'b1, 1'b0));
        tick();
        check("a_cnt_after_pop", 32'(a_cnt), 0);
        a_drive(1'b0, 8'h00, 1'b0);

        // Fill DEPTH=2, third beat stalls until a pop frees space
        a_drive(1'b1, 8'h21, 1'b0);
        tick();
        check("a_fill_cnt1",   32'(a_cnt), 1);
        check("a_fill_ready1", 32'(a_ready), 1);
        a_drive(1'b1, 8'h42, 1'b0);
        tick();
        check("a_fill_cnt2",   32'(a_cnt), 2);
        check("a_fill_ready2", 32'(a_ready), 0);
        a_drive(1'b1, 8'h63, 1'b0);
        tick();
        check("a_stall_cnt",   32'(a_cnt), 2);
        check("a_stall_ready", 32'(a_ready), 0);
        a_drive(1'b1, 8'h63, 1'b1);
        a_q.push_back(mk(4'd1, 12'd1, 1'b1, 1'b0));
        tick();
        check("a_pop1_cnt", 32'(a_cnt), 1);
        a_q.push_back(mk(4'd2, 12'd2, 1'b1, 1'b0));
        tick();
        check("a_push_pop_cnt", 32'(a_cnt), 1);
        a_drive(1'b0, 8'h00, 1'b1);
        a_q.push_back(mk(4'd3, 12'd3, 1'b1, 1'b0));
        tick();
        check("a_drain_cnt", 32'(a_cnt), 0);

        // ld_ir with a same-cycle push into an empty queue: no bypass
        a_drive(1'b1, 8'h11, 1'b1);
        a_q.push_back(mk(4'd3, 12'd3, 1'b1, 1'b1));
        tick();
        check("a_nobypass_cnt", 32'(a_cnt), 1);
        a_drive(1'b0, 8'h00, 1'b0);
        tick();
        check("a_nobypass_err_clr", 32'(a_err), 0);
        a_drive(1'b0, 8'h00, 1'b1);
        a_q.push_back(mk(4'd0, 12'd17, 1'b1, 1'b0));
        tick();
        a_drive(1'b0, 8'h00, 1'b0);

        // B: two-beat assembly C1,23 -> C / 123
        b_drive(1'b1, 8'hC1, 1'b0, 1'b0);
        tick();
        check("b_partial_cnt", 32'(b_cnt), 0);
        b_drive(1'b1, 8'h23, 1'b0, 1'b0);
        tick();
        check("b_full_cnt", 32'(b_cnt), 1);
        b_drive(1'b0, 8'h00, 1'b1, 1'b0);
        b_q.push_back(mk(4'hC, 12'h123, 1'b1, 1'b0));
        tick();
        check("b_pop_cnt", 32'(b_cnt), 0);

        // B: flush discards a partial beat; IR held; ld_ir ignored
        b_drive(1'b1, 8'hC1, 1'b0, 1'b0);
        tick();
        b_drive(1'b0, 8'h00, 1'b1, 1'b1);
        #1;
        check("b_flush_ready", 32'(b_ready), 0);
        tick();
        check("b_flush_cnt",  32'(b_cnt), 0);
        check("b_flush_err",  32'(b_err), 0);
        check("b_flush_opc",  32'(b_opc), 32'h0000_000C);
        check("b_flush_addr", 32'(b_adr), 32'h0000_0123);
        check("b_flush_irv",  32'(b_irv), 1);
        b_drive(1'b1, 8'h5A, 1'b0, 1'b0);
        tick();
        b_drive(1'b1, 8'hBC, 1'b0, 1'b0);
        tick();
        check("b_after_flush_cnt", 32'(b_cnt), 1);
        b_drive(1'b0, 8'h00, 1'b1, 1'b0);
        b_q.push_back(mk(4'h5, 12'hABC, 1'b1, 1'b0));
        tick();
        b_drive(1'b0, 8'h00, 1'b0, 1'b0);

        // B: steady stream with pop on every completing beat, pointers wrap mod 3
        b_drive(1'b1, {4'd0, 4'hA}, 1'b0, 1'b0);
        tick();
        b_drive(1'b1, 8'd0, 1'b0, 1'b0);
        tick();
        check("b_stream_prime_cnt", 32'(b_cnt), 1);
        for (int k = 1; k <= 10; k++) begin
            b_drive(1'b1, {4'(k), 4'hA}, 1'b0, 1'b0);
            tick();
            check("b_stream_beat1_cnt", 32'(b_cnt), 1);
            b_drive(1'b1, 8'(k * 3), 1'b1, 1'b0);
            b_q.push_back(mk(4'(k - 1), {4'hA, 8'((k - 1) * 3)}, 1'b1, 1'b0));
            tick();
            check("b_stream_beat2_cnt", 32'(b_cnt), 1);
        end
        b_drive(1'b0, 8'h00, 1'b1, 1'b0);
        b_q.push_back(mk(4'hA, 12'hA1E, 1'b1, 1'b0));
        tick();
        check("b_stream_drain_cnt", 32'(b_cnt), 0);

        // Asynchronous reset with one queued entry and a partial beat
        b_drive(1'b1, 8'h77, 1'b0, 1'b0);
        tick();
        b_drive(1'b1, 8'h88, 1'b0, 1'b0);
        tick();
        b_drive(1'b1, 8'h99, 1'b0, 1'b0);
        tick();
        b_drive(1'b0, 8'h00, 1'b0, 1'b0);
        #3;
        rst = 1'b1;
        #1;
        check("b_arst_opc",  32'(b_opc), 0);
        check("b_arst_addr", 32'(b_adr), 0);
        check("b_arst_irv",  32'(b_irv), 0);
        check("b_arst_cnt",  32'(b_cnt), 0);
        check("a_arst_addr", 32'(a_adr), 0);
        check("a_arst_irv",  32'(a_irv), 0);
        tick();
        rst = 1'b0;

        // Beat counter restarted: 12,34 -> 1 / 234
        b_drive(1'b1, 8'h12, 1'b0, 1'b0);
        tick();
        b_drive(1'b1, 8'h34, 1'b0, 1'b0);
        tick();
        check("b_post_rst_cnt", 32'(b_cnt), 1);
        b_drive(1'b0, 8'h00, 1'b1, 1'b0);
        b_q.push_back(mk(4'h1, 12'h234, 1'b1, 1'b0));
        tick();
        b_drive(1'b0, 8'h00, 1'b0, 1'b0);

        repeat (3) tick();
        check("a_sb_leftover", 32'(a_q.size()), 0);
        check("b_sb_leftover", 32'(b_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
